// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Covers access sizes, responder states, the default data base address and byte-lane store helpers.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    READ_RSP  = 3'd2,
    WRITE_RSP = 3'd3,
    ERR_RSP   = 3'd4
  } resp_state_t;

  localparam logic [31:0] DATA_BASE_ADDR = 32'h0000_2000;

  function automatic logic [3:0] store_byte_en(input logic [1:0] addr_lo, input logic [1:0] size);
    logic [3:0] be;
    case (size)
      MEM_BYTE: be = 4'b0001 << addr_lo;
      MEM_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Sub-word store data is replicated so any enabled lane sees the right bytes.
  function automatic logic [31:0] store_lane_data(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] lanes;
    case (size)
      MEM_BYTE: lanes = {4{data[7:0]}};
      MEM_HALF: lanes = {2{data[15:0]}};
      default:  lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic bad;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = addr_lo[0];
      MEM_WORD: bad = |addr_lo;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load extraction: selects the byte/half/word addressed by a load
// from the raw BRAM word and sign- or zero-extends it to 32 bits.
module riscv_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by size-dependent extension.
  always_comb begin
    byte_s = word_i[{byte_off_i, 3'b000} +: 8];
    half_s = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      MEM_BYTE: data_o = {{24{~unsigned_i & byte_s[7]}}, byte_s};
      MEM_HALF: data_o = {{16{~unsigned_i & half_s[15]}}, half_s};
      MEM_WORD: data_o = word_i;
      default:  data_o = word_i;
    endcase
  end

endmodule

// File: rtl/riscv_data_memory_responder.sv
// Data-memory responder: owns the data BRAM, performs byte-lane stores, aligned
// loads with extension, and range/alignment fault checks, answering each request with one pulse.
module riscv_data_memory_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DATA_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  output logic        req_ready,
  output logic [31:0] dReadData,
  output logic        rsp_valid,
  output logic        memError
);

  localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS) << 2;

  resp_state_t state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        mem_error_q, mem_error_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;

  logic [31:0]       offset_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic              accept_s;
  logic              fault_s;
  logic              store_s;
  logic              load_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [31:0]       aligned_s;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] bram_rdata_q;

  // Request decode: the subtraction wraps, so addresses below the base fail the range check too.
  always_comb begin
    offset_s   = dAddress - BASE_ADDR;
    word_idx_s = offset_s[ADDR_W+1:2];
    accept_s   = (MemRead | MemWrite) & req_ready_q;
    fault_s    = (MemRead & MemWrite)
               | (offset_s >= DEPTH_BYTES)
               | is_misaligned(dAddress[1:0], memSize);
    store_s    = accept_s & MemWrite & ~fault_s;
    load_s     = accept_s & MemRead & ~fault_s;
    be_s       = store_byte_en(dAddress[1:0], memSize);
    wdata_s    = store_lane_data(dWriteData, memSize);
  end

  // Data BRAM: byte-lane writes and synchronous read, contents never reset.
  always_ff @(posedge clk) begin
    if (store_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
    if (load_s) begin
      bram_rdata_q <= mem_q[word_idx_s];
    end
  end

  riscv_load_align u_load_align (
    .word_i     (bram_rdata_q),
    .byte_off_i (ld_off_q),
    .size_i     (ld_size_q),
    .unsigned_i (ld_uns_q),
    .data_o     (aligned_s)
  );

  // Responder FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (fault_s) begin
            state_d = ERR_RSP;
          end else if (MemWrite) begin
            state_d = WRITE_RSP;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ:      state_d = READ_RSP;
      READ_RSP:  state_d = IDLE;
      WRITE_RSP: state_d = IDLE;
      ERR_RSP:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output and load-context next values; outputs are decoded from the next state so they stay registered.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == WRITE_RSP) || (state_d == READ_RSP);
    mem_error_d = (state_d == ERR_RSP);
    if (state_q == READ) begin
      rdata_d = aligned_s;
    end else begin
      rdata_d = rdata_q;
    end
    if (load_s) begin
      ld_off_d  = dAddress[1:0];
      ld_size_d = memSize;
      ld_uns_d  = memUnsigned;
    end else begin
      ld_off_d  = ld_off_q;
      ld_size_d = ld_size_q;
      ld_uns_d  = ld_uns_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_error_q <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      ld_off_q    <= 2'b00;
      ld_size_q   <= 2'b00;
      ld_uns_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_error_q <= mem_error_d;
      rdata_q     <= rdata_d;
      ld_off_q    <= ld_off_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign memError  = mem_error_q;
  assign dReadData = rdata_q;

endmodule
